// File: rtl/acc_cpu_mc_if.sv
// Memory-side bus of the multi-cycle accumulator core: instruction fetch port and
// data read/write port, both against synchronous RAMs with one-cycle read latency.
interface acc_cpu_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 8
);
  logic [PC_W-1:0]   imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_re;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output dmem_addr,
    output dmem_re,
    output dmem_we,
    output dmem_wdata,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  dmem_addr,
    input  dmem_re,
    input  dmem_we,
    input  dmem_wdata,
    output dmem_rdata
  );
endinterface

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC/MEM/HALT sequencer with carry/zero
// flags, conditional jumps, halt, sticky illegal-opcode flag and retired-instruction counter.
module acc_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 8,
  parameter int OPC_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  acc_cpu_mc_if.master      bus,
  output logic [DATA_W-1:0] acc_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(8'h00);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(8'h03);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(8'h04);
  localparam logic [OPC_W-1:0] OP_ADDC = OPC_W'(8'h05);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(8'h06);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(8'h07);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(8'h08);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(8'h09);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(8'h0A);
  localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(8'h0B);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8'h0C);
  localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(8'h0D);
  localparam logic [OPC_W-1:0] OP_JC   = OPC_W'(8'h0E);
  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(8'h0F);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              c_q, c_d, z_q, z_d, ill_q, ill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] opnd;
  logic [PC_W-1:0]   pc_inc, jmp_tgt;
  logic [DATA_W:0]   sum_w, diff_w;
  logic              retire;

  assign opc     = ir_q[DATA_W-1 -: OPC_W];
  assign opnd    = ir_q[ADDR_W-1:0];
  assign pc_inc  = pc_q + PC_W'(1);
  assign jmp_tgt = opnd[PC_W-1:0];

  // Carry-in is only honoured for ADDC; borrow is the top bit of the widened difference.
  assign sum_w  = {1'b0, acc_q} + {1'b0, bus.dmem_rdata} + (DATA_W+1)'((opc == OP_ADDC) && c_q);
  assign diff_w = {1'b0, acc_q} - {1'b0, bus.dmem_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    ir_d        = ir_q;
    c_d         = c_q;
    z_d         = z_q;
    ill_d       = ill_q;
    retire      = 1'b0;
    bus.dmem_re = 1'b0;
    bus.dmem_we = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = bus.imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        retire  = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (opc)
          OP_NOP: ;
          OP_LDI: begin
            acc_d = {{(DATA_W-ADDR_W){1'b0}}, opnd};
            z_d   = (acc_d == '0);
          end
          OP_LD, OP_ADD, OP_ADDC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            bus.dmem_re = 1'b1;
            retire      = 1'b0;
            pc_d        = pc_q;
            state_d     = S_MEM;
          end
          OP_ST:  bus.dmem_we = 1'b1;
          OP_SHL: begin
            c_d   = acc_q[DATA_W-1];
            acc_d = {acc_q[DATA_W-2:0], 1'b0};
            z_d   = (acc_d == '0);
          end
          OP_SHR: begin
            c_d   = acc_q[0];
            acc_d = {1'b0, acc_q[DATA_W-1:1]};
            z_d   = (acc_d == '0);
          end
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (z_q) pc_d = jmp_tgt;
          OP_JC:  if (c_q) pc_d = jmp_tgt;
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ill_d = 1'b1;
        endcase
      end
      S_MEM: begin
        retire  = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (opc)
          OP_ADD, OP_ADDC: {c_d, acc_d} = sum_w;
          OP_SUB:          {c_d, acc_d} = diff_w;
          OP_AND:          acc_d = acc_q & bus.dmem_rdata;
          OP_OR:           acc_d = acc_q | bus.dmem_rdata;
          OP_XOR:          acc_d = acc_q ^ bus.dmem_rdata;
          default:         acc_d = bus.dmem_rdata;
        endcase
        z_d = (acc_d == '0);
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_addr  = opnd;
  assign bus.dmem_wdata = acc_q;
  assign acc_out        = acc_q;
  assign pc_out         = pc_q;
  assign flag_c         = c_q;
  assign flag_z         = z_q;
  assign halted         = (state_q == S_HALT);
  assign illegal        = ill_q;
  assign instr_cnt      = cnt_q;

endmodule
